// File: rtl/tinyqv_irq_ctrl.sv
// Interrupt controller for the TinyQV nibble-serial core: mie/mip/trigger-mode
// CSRs accessed one nibble per sub-cycle, with fixed-priority cause selection.
module tinyqv_irq_ctrl #(
    parameter int          NUM_IRQ      = 4,
    parameter logic [15:0] EDGE_DEFAULT = 16'h0003,
    parameter bit          AUTO_CLEAR   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         counter,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [3:0]         csr_wdata,
    output logic [3:0]         csr_rdata,
    output logic               csr_hit,
    input  logic               global_enable,
    input  logic               irq_ack,
    output logic               irq_pending,
    output logic [4:0]         taken_cause
);

    localparam logic [11:0] ADDR_MIE  = 12'h304;
    localparam logic [11:0] ADDR_MIP  = 12'h344;
    localparam logic [11:0] ADDR_MODE = 12'h7C0;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [NUM_IRQ-1:0] sync1_q;
    logic [NUM_IRQ-1:0] sync2_q;
    logic [NUM_IRQ-1:0] sdly_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [4:0]         cause_q, cause_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eff_pend;
    logic [NUM_IRQ-1:0] active;
    logic               any_active;
    logic [3:0]         sel;
    logic               op_live;
    logic               is_mie;
    logic               is_mip;
    logic               is_mode;
    logic               ack_now;
    logic               ack_clear;
    logic [31:0]        mie_word;
    logic [31:0]        mip_word;
    logic [31:0]        mode_word;
    logic [31:0]        rd_word;

    function automatic logic apply_op(input logic [1:0] op, input logic cur, input logic wd);
        logic res;
        case (op)
            OP_WRITE: res = wd;
            OP_SET:   res = cur | wd;
            OP_CLEAR: res = cur & ~wd;
            default:  res = cur;
        endcase
        return res;
    endfunction

    // Edge lines report their latched bit; level lines report the synchronised input directly.
    always_comb begin
        rise       = sync2_q & ~sdly_q;
        eff_pend   = (mode_q & pend_q) | (~mode_q & sync2_q);
        active     = eff_pend & mie_q;
        any_active = |active;
        sel        = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel = 4'(i);
            end
        end
        irq_pending = global_enable & any_active;
    end

    always_comb begin
        is_mie    = (csr_addr == ADDR_MIE);
        is_mip    = (csr_addr == ADDR_MIP);
        is_mode   = (csr_addr == ADDR_MODE);
        csr_hit   = is_mie | is_mip | is_mode;
        op_live   = (csr_op != OP_NONE);
        ack_now   = irq_ack & (counter == 3'd0);
        ack_clear = ack_now & AUTO_CLEAR & any_active;
    end

    always_comb begin
        mie_d   = mie_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        cause_d = cause_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (is_mie && op_live && counter == 3'(4 + i / 4)) begin
                mie_d[i] = apply_op(csr_op, mie_q[i], csr_wdata[i % 4]);
            end
            if (is_mip && op_live && mode_q[i] && counter == 3'(4 + i / 4)) begin
                pend_d[i] = apply_op(csr_op, pend_q[i], csr_wdata[i % 4]);
            end
            if (is_mode && op_live && counter == 3'(i / 4)) begin
                mode_d[i] = apply_op(csr_op, mode_q[i], csr_wdata[i % 4]);
            end
            if (ack_clear && mode_q[i] && sel == 4'(i)) begin
                pend_d[i] = 1'b0;
            end
        end
        // Level lines never hold a latched bit; a hardware edge overrides any clear this cycle.
        pend_d = (pend_d & mode_d) | (rise & mode_d);
        if (ack_now) begin
            cause_d = {1'b1, sel};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sdly_q  <= '0;
            pend_q  <= '0;
            mie_q   <= '0;
            mode_q  <= EDGE_DEFAULT[NUM_IRQ-1:0];
            cause_q <= 5'd0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            sdly_q  <= sync2_q;
            pend_q  <= pend_d;
            mie_q   <= mie_d;
            mode_q  <= mode_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        mie_word                  = '0;
        mip_word                  = '0;
        mode_word                 = '0;
        mie_word[16 +: NUM_IRQ]   = mie_q;
        mip_word[16 +: NUM_IRQ]   = eff_pend;
        mode_word[0 +: NUM_IRQ]   = mode_q;
        case (csr_addr)
            ADDR_MIE:  rd_word = mie_word;
            ADDR_MIP:  rd_word = mip_word;
            ADDR_MODE: rd_word = mode_word;
            default:   rd_word = '0;
        endcase
        csr_rdata = rd_word[{counter, 2'b00} +: 4];
    end

    assign taken_cause = cause_q;

endmodule

// File: tb/tb_tinyqv_irq_ctrl.sv
// Directed bench for tinyqv_irq_ctrl: a 4-line main instance plus 16- and
// 3-line instances sharing the CSR bus for width and reset checks.
module tb_tinyqv_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  counter;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [3:0]  csr_wdata;
    logic        global_enable;
    logic        irq_ack;

    logic [3:0]  irq_in4;
    logic [3:0]  rdata4;
    logic        hit4;
    logic        pend4;
    logic [4:0]  cause4;

    logic [15:0] irq_in16;
    logic [3:0]  rdata16;
    logic        hit16;
    logic        pend16o;
    logic [4:0]  cause16;

    logic [2:0]  irq_in3;
    logic [3:0]  rdata3;
    logic        hit3;
    logic        pend3o;
    logic [4:0]  cause3;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] w4, w16, w3;

    always #5 clk = ~clk;

    tinyqv_irq_ctrl #(.NUM_IRQ(4), .EDGE_DEFAULT(16'h0003), .AUTO_CLEAR(1'b1)) dut (
        .clk(clk), .rst(rst), .counter(counter), .irq_in(irq_in4),
        .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(rdata4), .csr_hit(hit4), .global_enable(global_enable),
        .irq_ack(irq_ack), .irq_pending(pend4), .taken_cause(cause4)
    );

    tinyqv_irq_ctrl #(.NUM_IRQ(16), .EDGE_DEFAULT(16'h0003), .AUTO_CLEAR(1'b1)) dut16 (
        .clk(clk), .rst(rst), .counter(counter), .irq_in(irq_in16),
        .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(rdata16), .csr_hit(hit16), .global_enable(global_enable),
        .irq_ack(irq_ack), .irq_pending(pend16o), .taken_cause(cause16)
    );

    tinyqv_irq_ctrl #(.NUM_IRQ(3), .EDGE_DEFAULT(16'h0003), .AUTO_CLEAR(1'b1)) dut3 (
        .clk(clk), .rst(rst), .counter(counter), .irq_in(irq_in3),
        .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(rdata3), .csr_hit(hit3), .global_enable(global_enable),
        .irq_ack(irq_ack), .irq_pending(pend3o), .taken_cause(cause3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; the sub-cycle index advances just after the edge and outputs settle before return.
    task automatic tick();
        @(posedge clk);
        #1;
        counter = counter + 3'd1;
        #1;
    endtask

    task automatic align0();
        while (counter != 3'd0) tick();
    endtask

    task automatic csr_access(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
        align0();
        csr_addr = addr;
        csr_op   = op;
        for (int k = 0; k < 8; k++) begin
            csr_wdata = wd[4*k +: 4];
            #1;
            w4[4*k +: 4]  = rdata4;
            w16[4*k +: 4] = rdata16;
            w3[4*k +: 4]  = rdata3;
            tick();
        end
        csr_addr  = 12'h000;
        csr_op    = 2'b00;
        csr_wdata = 4'h0;
    endtask

    task automatic ack_at_zero();
        align0();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        counter       = 3'd0;
        csr_addr      = 12'h000;
        csr_op        = 2'b00;
        csr_wdata     = 4'h0;
        global_enable = 1'b0;
        irq_ack       = 1'b0;
        irq_in4       = 4'h0;
        irq_in16      = 16'h0000;
        irq_in3       = 3'h0;

        // Reset defaults
        repeat (3) tick();
        check("rst_irq_pending", 32'(pend4), 32'd0);
        check("rst_cause", 32'(cause4), 32'd0);
        rst = 1'b0;
        tick();
        csr_access(12'h7C0, 2'b00, 32'h0);
        check("rst_mode4", w4, 32'h0000_0003);
        check("rst_mode16", w16, 32'h0000_0003);
        check("rst_mode3", w3, 32'h0000_0003);
        csr_access(12'h304, 2'b00, 32'h0);
        check("rst_mie", w4, 32'h0);
        csr_access(12'h344, 2'b00, 32'h0);
        check("rst_mip", w4, 32'h0);
        csr_addr = 12'h7C0;
        #1;
        check("hit_7c0", 32'(hit4), 32'd1);
        csr_addr = 12'h305;
        #1;
        check("hit_305", 32'(hit4), 32'd0);
        csr_addr = 12'h000;

        // Edge capture, latency and auto-clear
        global_enable = 1'b1;
        csr_access(12'h304, 2'b01, 32'h0001_0000);
        irq_in4 = 4'b0001;
        tick();
        check("edge_lat1", 32'(pend4), 32'd0);
        tick();
        check("edge_lat2", 32'(pend4), 32'd0);
        irq_in4 = 4'b0000;
        tick();
        check("edge_lat3", 32'(pend4), 32'd1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_off_slot_cause", 32'(cause4), 32'd0);
        check("ack_off_slot_pend", 32'(pend4), 32'd1);
        ack_at_zero();
        check("ack_cause_16", 32'(cause4), 32'd16);
        check("ack_autoclear", 32'(pend4), 32'd0);
        check("ack_none_pending", 32'(cause16), 32'd16);
        csr_access(12'h344, 2'b00, 32'h0);
        check("mip_after_ack", w4, 32'h0);

        // Level mode and priority
        csr_access(12'h7C0, 2'b01, 32'h0);
        csr_access(12'h304, 2'b01, 32'h000C_0000);
        irq_in4 = 4'b1100;
        tick();
        check("lvl_lat1", 32'(pend4), 32'd0);
        tick();
        check("lvl_lat2", 32'(pend4), 32'd1);
        csr_access(12'h344, 2'b00, 32'h0);
        check("mip_level", w4, 32'h000C_0000);
        ack_at_zero();
        check("prio_cause_18", 32'(cause4), 32'd18);
        check("lvl_no_autoclear", 32'(pend4), 32'd1);
        irq_in4 = 4'b1000;
        tick();
        tick();
        check("lvl_line3_still", 32'(pend4), 32'd1);
        ack_at_zero();
        check("prio_cause_19", 32'(cause4), 32'd19);
        irq_in4 = 4'b0000;
        tick();
        check("lvl_fall1", 32'(pend4), 32'd1);
        tick();
        check("lvl_fall2", 32'(pend4), 32'd0);

        // Set / clear with read-before-write
        csr_access(12'h304, 2'b01, 32'h0);
        csr_access(12'h304, 2'b10, 32'h000F_0000);
        check("rbw_set", w4, 32'h0);
        csr_access(12'h304, 2'b11, 32'h0005_0000);
        check("rbw_clear", w4, 32'h000F_0000);
        csr_access(12'h304, 2'b00, 32'h0);
        check("mie_after_clear", w4, 32'h000A_0000);
        csr_access(12'h304, 2'b01, 32'h000A_FFFF);
        csr_access(12'h304, 2'b00, 32'h0);
        check("mie_low_nibbles4", w4, 32'h000A_0000);
        check("mie_low_nibbles16", w16, 32'h000A_0000);

        // Edge-set beats a mip clear on the same edge
        csr_access(12'h7C0, 2'b01, 32'h3);
        align0();
        csr_addr = 12'h344;
        csr_op   = 2'b11;
        for (int k = 0; k < 8; k++) begin
            csr_wdata = (k == 4) ? 4'h2 : 4'h0;
            if (k == 2) irq_in4 = 4'b0010;
            if (k == 4) irq_in4 = 4'b0000;
            #1;
            tick();
        end
        csr_addr  = 12'h000;
        csr_op    = 2'b00;
        csr_wdata = 4'h0;
        csr_access(12'h344, 2'b00, 32'h0);
        check("race_set_beats_clear", w4, 32'h0002_0000);
        check("race_irq_pending", 32'(pend4), 32'd1);
        csr_access(12'h7C0, 2'b01, 32'h1);
        csr_access(12'h7C0, 2'b01, 32'h3);
        csr_access(12'h344, 2'b00, 32'h0);
        check("mode_switch_clears", w4, 32'h0);

        // Width masking and asynchronous reset mid-access
        csr_access(12'h304, 2'b01, 32'hFFFF_FFFF);
        csr_access(12'h7C0, 2'b01, 32'hFFFF_FFFF);
        csr_access(12'h304, 2'b00, 32'h0);
        check("mie_full16", w16, 32'hFFFF_0000);
        check("mie_full4", w4, 32'h000F_0000);
        check("mie_full3", w3, 32'h0007_0000);
        csr_access(12'h7C0, 2'b00, 32'h0);
        check("mode_full16", w16, 32'h0000_FFFF);
        check("mode_full3", w3, 32'h0000_0007);
        irq_in16 = 16'hFFFF;
        repeat (4) tick();
        check("all_pending16", 32'(pend16o), 32'd1);
        csr_access(12'h344, 2'b00, 32'h0);
        check("mip_full16", w16, 32'hFFFF_0000);
        align0();
        csr_addr  = 12'h304;
        csr_op    = 2'b10;
        csr_wdata = 4'h0;
        while (counter != 3'd5) tick();
        check("pre_rst_nib5", 32'(rdata16), 32'h0000_000F);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_nib5", 32'(rdata16), 32'd0);
        check("async_rst_pending", 32'(pend16o), 32'd0);
        check("async_rst_cause4", 32'(cause4), 32'd0);
        check("async_rst_cause16", 32'(cause16), 32'd0);
        csr_op = 2'b00;
        csr_access(12'h7C0, 2'b00, 32'h0);
        check("rst_mode16_again", w16, 32'h0000_0003);
        check("rst_mode3_again", w3, 32'h0000_0003);
        csr_access(12'h304, 2'b00, 32'h0);
        check("rst_mie16_again", w16, 32'h0);
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
